// File: rtl/inst_fetcher_pkg.sv
// Shared constants and state encoding for the instruction-fetch front end.
package inst_fetcher_pkg;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  localparam int          ADDR_W_DEF   = 32;
  localparam int          DATA_W_DEF   = 32;
  localparam logic [31:0] RESET_PC_DEF = 32'h0;
  localparam logic [31:0] PC_STEP      = 32'd4;

  // IDLE: nothing outstanding, WAIT: one request outstanding,
  // DROP: outstanding response belongs to a flushed path and is discarded.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/inst_fetcher_fetch_queue.sv
// In-order instruction queue of {pc, data} entries with flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_i,
  input  logic [AW-1:0] push_pc_i,
  input  logic [DW-1:0] push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [AW-1:0] head_pc_o,
  output logic [DW-1:0] head_data_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic [AW-1:0] pc_mem   [DEPTH];
  logic [DW-1:0] data_mem [DEPTH];

  // Pointers and occupancy; flush wins over any same-cycle push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) wr_q <= wr_q + 1'b1;
      if (pop_i)  rd_q <= rd_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Entry storage; contents are meaningless until written, so no reset.
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) begin
      pc_mem[wr_q]   <= push_pc_i;
      data_mem[wr_q] <= push_data_i;
    end
  end

  assign head_pc_o   = pc_mem[rd_q];
  assign head_data_o = data_mem[rd_q];
  assign full_o      = (cnt_q == CW'(DEPTH));
  assign empty_o     = (cnt_q == '0);

endmodule

// File: rtl/inst_fetcher.sv
// Fetch front end: PC, single-outstanding fetch FSM, queue, fetch statistic.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int                    QUEUE_DEPTH = 4,
  parameter int                    ADDR_WIDTH  = ADDR_W_DEF,
  parameter int                    DATA_WIDTH  = DATA_W_DEF,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = ADDR_WIDTH'(RESET_PC_DEF)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  chip_enable,
  input  logic                  update_stat,
  output logic                  req_valid,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  resp_valid,
  input  logic [DATA_WIDTH-1:0] resp_data,
  input  logic                  jump_valid,
  input  logic [ADDR_WIDTH-1:0] jump_pc,
  output logic                  inst_valid,
  output logic [ADDR_WIDTH-1:0] inst_pc,
  output logic [DATA_WIDTH-1:0] inst_data,
  input  logic                  inst_ready,
  output logic [31:0]           stat_fetch_cnt
);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
  logic                  req_valid_q, req_valid_d;
  logic [31:0]           fcnt_q, fcnt_d, stat_q, stat_d;
  logic                  seen_q, seen_d;
  logic                  q_push, q_pop, q_flush, q_full, q_empty;

  fetch_queue #(
    .DEPTH (QUEUE_DEPTH),
    .AW    (ADDR_WIDTH),
    .DW    (DATA_WIDTH)
  ) u_queue (
    .clk         (clk),
    .rst         (rst),
    .push_i      (q_push),
    .push_pc_i   (pc_q),
    .push_data_i (resp_data),
    .pop_i       (q_pop),
    .flush_i     (q_flush),
    .head_pc_o   (inst_pc),
    .head_data_o (inst_data),
    .full_o      (q_full),
    .empty_o     (q_empty)
  );

  // State registers; chip_enable low is handled by holding every _d at _q.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      pc_q        <= RESET_PC;
      req_valid_q <= FALSE;
      req_addr_q  <= RESET_PC;
      fcnt_q      <= '0;
      stat_q      <= '0;
      seen_q      <= FALSE;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      req_valid_q <= req_valid_d;
      req_addr_q  <= req_addr_d;
      fcnt_q      <= fcnt_d;
      stat_q      <= stat_d;
      seen_q      <= seen_d;
    end
  end

  // Next state: jump has priority, then issue/collect/discard per state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_valid_d = req_valid_q;
    req_addr_d  = req_addr_q;
    fcnt_d      = fcnt_q;
    stat_d      = stat_q;
    seen_d      = seen_q;
    q_push      = FALSE;
    q_pop       = FALSE;
    q_flush     = FALSE;
    if (chip_enable) begin
      req_valid_d = FALSE;
      q_pop       = !q_empty && inst_ready && !jump_valid;
      if (jump_valid) begin
        q_flush = TRUE;
        pc_d    = jump_pc;
        // An outstanding request whose response hasn't arrived must be dropped later.
        state_d = (state_q == IDLE || resp_valid) ? IDLE : DROP;
      end else begin
        case (state_q)
          IDLE: if (!q_full) begin
            req_valid_d = TRUE;
            req_addr_d  = pc_q;
            state_d     = WAIT;
          end
          WAIT: if (resp_valid) begin
            q_push  = TRUE;
            pc_d    = pc_q + ADDR_WIDTH'(PC_STEP);
            fcnt_d  = fcnt_q + 32'd1;
            state_d = IDLE;
          end
          DROP: if (resp_valid) state_d = IDLE;
          default: state_d = IDLE;
        endcase
      end
      // Snapshot uses the count from before any same-cycle fetch.
      if (update_stat != seen_q) begin
        stat_d = fcnt_q;
        seen_d = update_stat;
      end
    end
  end

  assign req_valid      = chip_enable && req_valid_q;
  assign req_addr       = req_addr_q;
  assign inst_valid     = chip_enable && !q_empty;
  assign stat_fetch_cnt = stat_q;

endmodule
